// File: rtl/cpu_step_ctrl_if.sv
// Front-panel control/status bundle for cpu_step_ctrl: run/step requests, CPU
// fetch/PC observation, breakpoint setup, and the clock-enable/status outputs.
interface cpu_step_ctrl_if #(
   parameter int PC_W    = 32,
   parameter int CNT_W   = 16,
   parameter int BURST_W = 8
);
   logic               run_sw;
   logic               gran;
   logic               step_pulse;
   logic [BURST_W-1:0] burst_len;
   logic               fetch;
   logic [PC_W-1:0]    pc;
   logic [PC_W-1:0]    bp_addr;
   logic               bp_en;
   logic               cnt_clr;
   logic               cpu_en;
   logic               halted;
   logic               bp_hit;
   logic [CNT_W-1:0]   cyc_cnt;
   logic [CNT_W-1:0]   ins_cnt;
   logic [1:0]         state;

   modport slave (
      input  run_sw, gran, step_pulse, burst_len, fetch, pc, bp_addr, bp_en, cnt_clr,
      output cpu_en, halted, bp_hit, cyc_cnt, ins_cnt, state
   );

   modport master (
      output run_sw, gran, step_pulse, burst_len, fetch, pc, bp_addr, bp_en, cnt_clr,
      input  cpu_en, halted, bp_hit, cyc_cnt, ins_cnt, state
   );
endinterface

// File: rtl/cpu_step_ctrl.sv
// CPU run/single-step controller producing the CPU clock enable and cycle/instruction
// counters. Breakpoint support is built only when CPU_STEP_CTRL_BP_EN is defined.
module cpu_step_ctrl #(
   parameter int PC_W    = 32,
   parameter int CNT_W   = 16,
   parameter int BURST_W = 8
) (
   input logic              clk,
   input logic              RSTN,
   cpu_step_ctrl_if.slave   bus
);
   typedef enum logic [1:0] {
      ST_HALT = 2'd0,
      ST_RUN  = 2'd1,
      ST_STEP = 2'd2
   } state_e;

   localparam logic [BURST_W-1:0] REM_ONE  = BURST_W'(1);
   localparam logic [BURST_W-1:0] REM_ZERO = BURST_W'(0);

   state_e             state_q, state_d;
   logic [BURST_W-1:0] rem_q, rem_d;
   logic               gran_q, gran_d;
   logic               first_q, first_d;
   logic               bp_hit_q;
   logic [CNT_W-1:0]   cyc_q, ins_q;
   logic               bp_take_s, boundary_s, cpu_en_s;
   logic [PC_W-1:0]    pc_s, bp_addr_s;

   assign pc_s      = bus.pc;
   assign bp_addr_s = bus.bp_addr;

`ifdef CPU_STEP_CTRL_BP_EN
   // first_q masks the cycle just after leaving HALT so a stop at a breakpoint can be stepped past.
   assign bp_take_s = ((state_q == ST_RUN) || (state_q == ST_STEP)) && bus.fetch && bus.bp_en
                      && (pc_s == bp_addr_s) && !first_q;
`else
   logic unused_bp_s;
   assign unused_bp_s = ^{bus.bp_en, pc_s, bp_addr_s};
   assign bp_take_s   = 1'b0;
   assign bp_hit_q    = 1'b0;
`endif

   assign boundary_s = (state_q == ST_STEP) && gran_q && bus.fetch && !first_q;

   // Clock enable decode; independent of run_sw and step_pulse.
   always_comb begin
      cpu_en_s = 1'b0;
      case (state_q)
         ST_RUN:  cpu_en_s = !bp_take_s;
         ST_STEP: begin
            if (bp_take_s) begin
               cpu_en_s = 1'b0;
            end else if (boundary_s && (rem_q == REM_ONE)) begin
               cpu_en_s = 1'b0;
            end else begin
               cpu_en_s = 1'b1;
            end
         end
         default: cpu_en_s = 1'b0;
      endcase
   end

   // Next-state, remaining-unit and sampled-granularity decode.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      gran_d  = gran_q;
      first_d = 1'b0;
      case (state_q)
         ST_HALT: begin
            if (bus.step_pulse) begin
               state_d = ST_STEP;
               rem_d   = (bus.burst_len == REM_ZERO) ? REM_ONE : bus.burst_len;
               gran_d  = bus.gran;
               first_d = 1'b1;
            end else if (bus.run_sw && !bp_hit_q) begin
               state_d = ST_RUN;
               first_d = 1'b1;
            end else begin
               state_d = ST_HALT;
            end
         end
         ST_RUN: begin
            if (bp_take_s || !bus.run_sw) begin
               state_d = ST_HALT;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_STEP: begin
            if (bp_take_s) begin
               state_d = ST_HALT;
               rem_d   = REM_ZERO;
            end else if (!gran_q || boundary_s) begin
               rem_d   = rem_q - REM_ONE;
               state_d = (rem_q == REM_ONE) ? ST_HALT : ST_STEP;
            end else begin
               state_d = ST_STEP;
            end
         end
         default: begin
            state_d = ST_HALT;
            rem_d   = REM_ZERO;
         end
      endcase
   end

   // Controller state, sticky breakpoint flag and enabled-cycle counters.
   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
         state_q  <= ST_HALT;
         rem_q    <= REM_ZERO;
         gran_q   <= 1'b0;
         first_q  <= 1'b0;
         cyc_q    <= CNT_W'(0);
         ins_q    <= CNT_W'(0);
`ifdef CPU_STEP_CTRL_BP_EN
         bp_hit_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         gran_q   <= gran_d;
         first_q  <= first_d;
`ifdef CPU_STEP_CTRL_BP_EN
         if (bp_take_s) begin
            bp_hit_q <= 1'b1;
         end else if ((state_q == ST_HALT) && bus.step_pulse) begin
            bp_hit_q <= 1'b0;
         end else begin
            bp_hit_q <= bp_hit_q;
         end
`endif
         if (bus.cnt_clr) begin
            cyc_q <= CNT_W'(0);
            ins_q <= CNT_W'(0);
         end else begin
            cyc_q <= cyc_q + CNT_W'(cpu_en_s);
            ins_q <= ins_q + CNT_W'(cpu_en_s & bus.fetch);
         end
      end
   end

   assign bus.cpu_en  = cpu_en_s;
   assign bus.halted  = (state_q == ST_HALT);
   assign bus.bp_hit  = bp_hit_q;
   assign bus.cyc_cnt = cyc_q;
   assign bus.ins_cnt = ins_q;
   assign bus.state   = state_q;
endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Self-checking bench for cpu_step_ctrl with a 4-beat-per-instruction CPU model.
module tb_cpu_step_ctrl;
   localparam int PC_W = 32, CNT_W = 16, BURST_W = 8;

   logic clk  = 1'b0;
   logic RSTN = 1'b0;
   always #5 clk = ~clk;

   cpu_step_ctrl_if #(.PC_W(PC_W), .CNT_W(CNT_W), .BURST_W(BURST_W)) bus ();
   cpu_step_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
      .clk(clk), .RSTN(RSTN), .bus(bus)
   );

   // CPU model: each instruction is 4 enabled beats, beat 0 is the fetch.
   logic [1:0]      beat;
   logic [PC_W-1:0] cpu_pc;
   logic            cpu_load = 1'b1;
   logic [PC_W-1:0] cpu_load_pc = 32'h0;
   always @(posedge clk) begin
      if (cpu_load) begin
         beat   <= 2'd0;
         cpu_pc <= cpu_load_pc;
      end else if (bus.cpu_en) begin
         beat <= beat + 2'd1;
         if (beat == 2'd3) cpu_pc <= cpu_pc + 32'd4;
      end
   end
   assign bus.fetch = (beat == 2'd0);
   assign bus.pc    = cpu_pc;

   int unsigned en_seen = 0;
   always @(posedge clk) if (bus.cpu_en === 1'b1) en_seen <= en_seen + 1;

   typedef struct { logic gran; logic [7:0] len; int unsigned cyc; int unsigned ins; } vec_t;
   typedef struct { int unsigned cyc; int unsigned ins; logic gran; } exp_t;
   vec_t tbl[10];
   exp_t sb[$];
   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clr_and_load(input logic [PC_W-1:0] pc0);
      @(negedge clk);
      bus.cnt_clr = 1'b1; cpu_load = 1'b1; cpu_load_pc = pc0;
      @(negedge clk);
      bus.cnt_clr = 1'b0; cpu_load = 1'b0;
   endtask

   task automatic wait_halt(input string name);
      int n = 0;
      while (bus.halted !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
      check(name, 32'(n < 3000), 32'd1);
   endtask

   task automatic score(input string name, input int unsigned en0);
      exp_t e;
      e = sb.pop_front();
      check({name, "_cyc"}, 32'(bus.cyc_cnt), e.cyc);
      check({name, "_ins"}, 32'(bus.ins_cnt), e.ins);
      check({name, "_en"}, en_seen - en0, e.cyc);
      check({name, "_halted"}, 32'(bus.halted), 32'd1);
      if (e.gran) check({name, "_fetch"}, 32'(bus.fetch), 32'd1);
   endtask

   task automatic run_burst(input logic g, input logic [7:0] len, input int unsigned ecyc,
                            input int unsigned eins);
      int unsigned en0;
      clr_and_load(32'h0);
      sb.push_back('{ecyc, eins, g});
      en0 = en_seen;
      bus.gran = g; bus.burst_len = len; bus.step_pulse = 1'b1;
      @(negedge clk);
      bus.step_pulse = 1'b0;
      check("burst_enter", 32'(bus.state), 32'd2);
      wait_halt("burst_timeout");
      score("burst", en0);
   endtask

   task automatic run_fixed(input int k, input int unsigned eins);
      int unsigned en0;
      clr_and_load(32'h0);
      sb.push_back('{32'(k), eins, 1'b0});
      en0 = en_seen;
      bus.run_sw = 1'b1;
      repeat (k / 2) @(negedge clk);
      bus.step_pulse = 1'b1;
      @(negedge clk);
      bus.step_pulse = 1'b0;
      repeat (k - k / 2 - 1) @(negedge clk);
      bus.run_sw = 1'b0;
      #1 check("run_last_en", 32'(bus.cpu_en), 32'd1);
      @(negedge clk);
      check("run_stop_state", 32'(bus.state), 32'd0);
      check("run_bp_hit", 32'(bus.bp_hit), 32'd0);
      score("run", en0);
   endtask

   initial begin
      int n;
      int unsigned en0;
      tbl[0] = '{1'b0, 8'd0,   1,   1};
      tbl[1] = '{1'b0, 8'd1,   1,   1};
      tbl[2] = '{1'b0, 8'd5,   5,   2};
      tbl[3] = '{1'b0, 8'd8,   8,   2};
      tbl[4] = '{1'b0, 8'd255, 255, 64};
      tbl[5] = '{1'b1, 8'd0,   4,   1};
      tbl[6] = '{1'b1, 8'd1,   4,   1};
      tbl[7] = '{1'b1, 8'd3,   12,  3};
      tbl[8] = '{1'b1, 8'd2,   8,   2};
      tbl[9] = '{1'b0, 8'd3,   3,   1};

      bus.run_sw = 1'b0; bus.gran = 1'b0; bus.step_pulse = 1'b0; bus.burst_len = 8'd0;
      bus.bp_addr = 32'h10; bus.bp_en = 1'b0; bus.cnt_clr = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_state", 32'(bus.state), 32'd0);
      check("rst_cpu_en", 32'(bus.cpu_en), 32'd0);
      check("rst_halted", 32'(bus.halted), 32'd1);
      check("rst_bp_hit", 32'(bus.bp_hit), 32'd0);
      check("rst_cyc", 32'(bus.cyc_cnt), 32'd0);
      check("rst_ins", 32'(bus.ins_cnt), 32'd0);
      RSTN = 1'b1;
      cpu_load = 1'b0;

      for (int i = 0; i < 10; i++) run_burst(tbl[i].gran, tbl[i].len, tbl[i].cyc, tbl[i].ins);

      // gran held for the whole burst; step_pulse/run_sw ignored mid-burst
      clr_and_load(32'h0);
      sb.push_back('{32'd8, 32'd2, 1'b1});
      en0 = en_seen;
      bus.gran = 1'b1; bus.burst_len = 8'd2; bus.step_pulse = 1'b1;
      @(negedge clk);
      bus.step_pulse = 1'b0;
      repeat (2) @(negedge clk);
      bus.gran = 1'b0; bus.step_pulse = 1'b1; bus.run_sw = 1'b1;
      @(negedge clk);
      bus.step_pulse = 1'b0; bus.run_sw = 1'b0;
      wait_halt("hold_timeout");
      score("hold", en0);

      run_fixed(20, 5);

`ifdef CPU_STEP_CTRL_BP_EN
      clr_and_load(32'h0);
      en0 = en_seen;
      bus.bp_en = 1'b1; bus.bp_addr = 32'h10; bus.run_sw = 1'b1;
      @(negedge clk);
      wait_halt("bp_timeout");
      check("bp_cyc", 32'(bus.cyc_cnt), 32'd16);
      check("bp_en_cnt", en_seen - en0, 32'd16);
      check("bp_hit_set", 32'(bus.bp_hit), 32'd1);
      check("bp_pc", bus.pc, 32'h10);
      check("bp_state", 32'(bus.state), 32'd0);
      repeat (5) @(negedge clk);
      check("bp_no_rerun", 32'(bus.halted), 32'd1);
      check("bp_no_rerun_cyc", 32'(bus.cyc_cnt), 32'd16);
      bus.gran = 1'b1; bus.burst_len = 8'd1; bus.step_pulse = 1'b1;
      @(negedge clk);
      bus.step_pulse = 1'b0;
      check("bp_clear", 32'(bus.bp_hit), 32'd0);
      check("bp_step_state", 32'(bus.state), 32'd2);
      n = 0;
      while (bus.state !== 2'd1 && n < 100) begin @(negedge clk); n++; end
      check("bp_resume", 32'(n < 100), 32'd1);
      check("bp_resume_cyc", 32'(bus.cyc_cnt), 32'd20);
      check("bp_resume_pc", bus.pc, 32'h14);
      bus.run_sw = 1'b0; bus.bp_en = 1'b0;
      @(negedge clk);
      wait_halt("bp_stop");
`else
      bus.bp_en = 1'b1; bus.bp_addr = 32'h10;
      run_fixed(30, 8);
      bus.bp_en = 1'b0;
`endif

      // counter wrap in free run, then clear while enabled
      clr_and_load(32'h0);
      bus.run_sw = 1'b1;
      n = 0;
      while (bus.cyc_cnt !== 16'hFFFF && n < 70000) begin @(negedge clk); n++; end
      check("wrap_reach", 32'(n < 70000), 32'd1);
      @(negedge clk);
      check("wrap_cyc", 32'(bus.cyc_cnt), 32'h0);
      check("wrap_ins", 32'(bus.ins_cnt), 32'h4000);
      bus.cnt_clr = 1'b1;
      #1 check("clr_en", 32'(bus.cpu_en), 32'd1);
      @(negedge clk);
      bus.cnt_clr = 1'b0;
      check("clr_cyc", 32'(bus.cyc_cnt), 32'd0);
      check("clr_ins", 32'(bus.ins_cnt), 32'd0);
      @(negedge clk);
      check("clr_resume", 32'(bus.cyc_cnt), 32'd1);
      bus.run_sw = 1'b0;
      @(negedge clk);
      wait_halt("wrap_stop");

      // reset in the middle of a 5-instruction burst
      clr_and_load(32'h0);
      bus.gran = 1'b1; bus.burst_len = 8'd5; bus.step_pulse = 1'b1;
      @(negedge clk);
      bus.step_pulse = 1'b0;
      n = 0;
      while (bus.ins_cnt !== 16'd2 && n < 100) begin @(negedge clk); n++; end
      check("mid_reach", 32'(n < 100), 32'd1);
      RSTN = 1'b0;
      #1;
      check("mid_state", 32'(bus.state), 32'd0);
      check("mid_cpu_en", 32'(bus.cpu_en), 32'd0);
      check("mid_halted", 32'(bus.halted), 32'd1);
      check("mid_bp_hit", 32'(bus.bp_hit), 32'd0);
      check("mid_cyc", 32'(bus.cyc_cnt), 32'd0);
      check("mid_ins", 32'(bus.ins_cnt), 32'd0);
      @(negedge clk);
      RSTN = 1'b1;
      repeat (3) @(negedge clk);
      check("mid_wait_halted", 32'(bus.halted), 32'd1);
      check("mid_wait_cyc", 32'(bus.cyc_cnt), 32'd0);
      run_burst(1'b0, 8'd3, 3, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cpu_step_ctrl.md
CPU_STEP_CTRL -- requirements
Module: cpu_step_ctrl

Interface
REQ-001 Parameter PC_W, 32, width of pc and bp_addr.
REQ-002 Parameter CNT_W, 16, width of cyc_cnt and ins_cnt.
REQ-003 Parameter BURST_W, 8, width of burst_len and the internal remaining-step counter.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port RSTN, input, 1: reset, asynchronous assert, active-low.
REQ-006 Port run_sw, input, 1: free-run request; level-sensitive.
REQ-007 Port gran, input, 1: step unit; 0 = clock cycle, 1 = instruction.
REQ-008 Port step_pulse, input, 1: one-clk debounced step request.
REQ-009 Port burst_len, input, BURST_W: units per step request; 0 is treated as 1.
REQ-010 Port fetch, input, 1: CPU is in its fetch beat this cycle, i.e. at an instruction boundary.
REQ-011 Port pc, input, PC_W: current CPU PC.
REQ-012 Port bp_addr, input, PC_W: breakpoint address.
REQ-013 Port bp_en, input, 1: breakpoint enable.
REQ-014 Port cnt_clr, input, 1: synchronous clear of both counters.
REQ-015 Port cpu_en, output, 1: CPU clock enable.
REQ-016 Port halted, output, 1: high when state == HALT.
REQ-017 Port bp_hit, output, 1: sticky breakpoint-taken flag.
REQ-018 Port cyc_cnt, output, CNT_W: count of enabled cycles.
REQ-019 Port ins_cnt, output, CNT_W: count of enabled fetch cycles.
REQ-020 Port state, output, 2: HALT = 0, RUN = 1, STEP = 2; 3 is unused.

Function
REQ-021 State HALT shall drive cpu_en = 0 and make the following transitions:
- if step_pulse = 1: go to STEP, load remaining = max(burst_len, 1), clear bp_hit.
- else if run_sw = 1 and bp_hit = 0: go to RUN.
- step_pulse takes priority when both are true.
REQ-022 State RUN shall drive cpu_en = 1 and go to HALT on the next edge if run_sw = 0; cpu_en stays 1 in the cycle in which run_sw = 0 is sampled.
REQ-023 State STEP with gran = 0 shall enable every cycle, decrementing remaining on each one; when remaining = 1 is decremented, the next state is HALT.
REQ-024 State STEP with gran = 1 shall treat a cycle with fetch = 1 as a unit boundary once at least one enabled cycle has occurred since entering STEP:
- if remaining = 1 at the boundary: cpu_en = 0 in that cycle and go to HALT.
- otherwise: decrement remaining and keep cpu_en = 1.
REQ-025 gran shall be sampled only on the HALT to STEP transition and held for the whole burst.
REQ-026 In STEP, step_pulse and run_sw shall be ignored; a burst always completes unless a breakpoint is taken.
REQ-027 In RUN, step_pulse shall be ignored.
REQ-028 cpu_en shall be combinational from state, remaining, fetch and the breakpoint compare; it shall have no dependence on step_pulse or run_sw in the same cycle.
REQ-029 cyc_cnt shall increment on every cycle with cpu_en = 1; ins_cnt shall increment on every cycle with cpu_en = 1 and fetch = 1.
REQ-030 Both counters shall wrap modulo 2^CNT_W.
REQ-031 cnt_clr shall take priority over increment and zero both counters on the next edge.
REQ-032 A breakpoint is taken in a cycle where all of the following hold: the state is RUN or STEP, fetch = 1, bp_en = 1, pc == bp_addr, and it is not the first cycle after leaving HALT. When taken:
- cpu_en = 0 in that cycle.
- the next state is HALT.
- bp_hit is set.
- a breakpoint overrides STEP unit completion in the same cycle.

Reset
REQ-033 While RSTN = 0 the block shall hold: state = HALT, cpu_en = 0, halted = 1, bp_hit = 0, cyc_cnt = 0, ins_cnt = 0, remaining = 0, first-cycle flag cleared.
REQ-034 RSTN asserted mid-burst or mid-run shall abort immediately; after release the block waits in HALT for a fresh request.

Configuration
REQ-035 Macro CPU_STEP_CTRL_BP_EN shall control breakpoint support:
- defined: breakpoint logic per REQ-032 is present.
- undefined: bp_en and bp_addr are ignored, bp_hit is tied to 0, and no comparator is built.

Verification
REQ-036 Release reset, run_sw = 0, gran = 0, burst_len = 0, one step_pulse -> exactly 1 enabled cycle, cyc_cnt = 1, then HALT.
REQ-037 gran = 1, burst_len = 3, CPU fetch every 4th cycle with fetch = 1 at start -> 12 enabled cycles, ins_cnt = 3, halted with fetch = 1.
REQ-038 run_sw = 1, bp_en = 1, bp_addr = 0x10, pc reaching 0x10 at fetch -> cpu_en = 0 that cycle, bp_hit = 1, state HALT, no re-run while run_sw stays 1.
REQ-039 After REQ-038, step_pulse with gran = 1 -> bp_hit clears, the instruction at 0x10 executes without re-trigger, and RUN resumes afterwards.
REQ-040 cyc_cnt preset near 0xFFFF in free run -> wraps to 0x0000; cnt_clr together with cpu_en = 1 -> both counters read 0.
REQ-041 RSTN low during a burst of 5 at unit 2 -> immediate HALT with all outputs at reset values; a further step_pulse starts a fresh burst.
